// File: rtl/connection_table_ctrl_if.sv
// Requester and table-side signal bundle for connection_table_ctrl.
// slave = controller view, master = requesters plus table view.
interface connection_table_ctrl_if #(
  parameter int DATA_WIDTH        = 6,
  parameter int NODE_ADDRESS_SIZE = 4
);
  localparam int DW  = DATA_WIDTH;
  localparam int NAS = NODE_ADDRESS_SIZE;

  logic           init_done;
  logic           req0;
  logic           req1;
  logic           we0;
  logic           we1;
  logic [NAS-1:0] node_A0;
  logic [NAS-1:0] node_B0;
  logic [NAS-1:0] node_A1;
  logic [NAS-1:0] node_B1;
  logic [DW-1:0]  wdata0;
  logic [DW-1:0]  wdata1;
  logic           gnt0;
  logic           gnt1;
  logic           rvalid0;
  logic           rvalid1;
  logic [DW-1:0]  rdata;
  logic [NAS-1:0] mem_node_A;
  logic [NAS-1:0] mem_node_B;
  logic [DW-1:0]  mem_IN;
  logic           mem_we;
  logic           mem_cs;
  logic [DW-1:0]  mem_OUT;

  modport slave (
    input  req0, req1, we0, we1,
    input  node_A0, node_B0, node_A1, node_B1,
    input  wdata0, wdata1, mem_OUT,
    output init_done, gnt0, gnt1,
    output rvalid0, rvalid1, rdata,
    output mem_node_A, mem_node_B,
    output mem_IN, mem_we, mem_cs
  );

  modport master (
    output req0, req1, we0, we1,
    output node_A0, node_B0, node_A1, node_B1,
    output wdata0, wdata1, mem_OUT,
    input  init_done, gnt0, gnt1,
    input  rvalid0, rvalid1, rdata,
    input  mem_node_A, mem_node_B,
    input  mem_IN, mem_we, mem_cs
  );
endinterface

// File: rtl/connection_table_ctrl.sv
// Clears the connection table after reset, then arbitrates two
// requesters round-robin, optionally mirroring writes to (B,A).
module connection_table_ctrl #(
  parameter int DATA_WIDTH        = 6,
  parameter int NODE_ADDRESS_SIZE = 4,
  parameter int MIRROR_WRITES     = 1
) (
  input  logic CLK,
  input  logic RST,
  connection_table_ctrl_if.slave bus
);
  localparam int DW  = DATA_WIDTH;
  localparam int NAS = NODE_ADDRESS_SIZE;
  localparam int AW  = 2 * NAS;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    RUN    = 2'd1,
    MIRROR = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           prio_q, prio_d;
  logic           rv0_q, rv0_d;
  logic           rv1_q, rv1_d;
  logic [NAS-1:0] mir_a_q, mir_a_d;
  logic [NAS-1:0] mir_b_q, mir_b_d;
  logic [DW-1:0]  mir_d_q, mir_d_d;

  logic           g0, g1;
  logic           sel_we;
  logic [NAS-1:0] sel_a, sel_b;
  logic [DW-1:0]  sel_d;
  logic           cs, we;
  logic [NAS-1:0] ma, mb;
  logic [DW-1:0]  mi;

  always_comb begin
    g0      = 1'b0;
    g1      = 1'b0;
    sel_we  = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    sel_d   = '0;
    cs      = 1'b0;
    we      = 1'b0;
    ma      = '0;
    mb      = '0;
    mi      = '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    mir_a_d = mir_a_q;
    mir_b_d = mir_b_q;
    mir_d_d = mir_d_q;

    unique case (state_q)
      CLEAR: begin
        cs       = 1'b1;
        we       = 1'b1;
        {ma, mb} = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: begin
        g0 = bus.req0 & (~bus.req1 | ~prio_q);
        g1 = bus.req1 & (~bus.req0 | prio_q);
        if (g1) begin
          sel_we = bus.we1;
          sel_a  = bus.node_A1;
          sel_b  = bus.node_B1;
          sel_d  = bus.wdata1;
        end else begin
          sel_we = bus.we0;
          sel_a  = bus.node_A0;
          sel_b  = bus.node_B0;
          sel_d  = bus.wdata0;
        end
        if (g0 | g1) begin
          cs     = 1'b1;
          we     = sel_we;
          ma     = sel_a;
          mb     = sel_b;
          mi     = sel_d;
          prio_d = g0;
          rv0_d  = g0 & ~bus.we0;
          rv1_d  = g1 & ~bus.we1;
          if (sel_we && MIRROR_WRITES != 0
              && sel_a != sel_b) begin
            mir_a_d = sel_a;
            mir_b_d = sel_b;
            mir_d_d = sel_d;
            state_d = MIRROR;
          end
        end
      end
      MIRROR: begin
        cs      = 1'b1;
        we      = 1'b1;
        ma      = mir_b_q;
        mb      = mir_a_q;
        mi      = mir_d_q;
        state_d = RUN;
      end
      default: state_d = CLEAR;
    endcase

    // reset wins in the same cycle: no access may reach the table
    if (RST) begin
      g0 = 1'b0;
      g1 = 1'b0;
      cs = 1'b0;
      we = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      mir_a_q <= '0;
      mir_b_q <= '0;
      mir_d_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      mir_a_q <= mir_a_d;
      mir_b_q <= mir_b_d;
      mir_d_q <= mir_d_d;
    end
  end

  assign bus.init_done  = (state_q != CLEAR);
  assign bus.gnt0       = g0;
  assign bus.gnt1       = g1;
  assign bus.rvalid0    = rv0_q;
  assign bus.rvalid1    = rv1_q;
  assign bus.rdata      = bus.mem_OUT;
  assign bus.mem_cs     = cs;
  assign bus.mem_we     = we;
  assign bus.mem_node_A = ma;
  assign bus.mem_node_B = mb;
  assign bus.mem_IN     = mi;
endmodule

// File: tb/tb_connection_table_ctrl.sv
// Directed bench for connection_table_ctrl with a behavioural
// table and a read-result scoreboard.
module tb_connection_table_ctrl;
  localparam int DW  = 6;
  localparam int NAS = 4;
  localparam int N   = 1 << (2 * NAS);

  typedef struct {
    logic [31:0] port;
    logic [31:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic scramble = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   npush = 0;
  int   npop = 0;
  exp_t exp_q[$];
  int   refm[N];
  logic [DW-1:0] tmem[N];
  logic [DW-1:0] mout;

  connection_table_ctrl_if #(.DATA_WIDTH(DW), .NODE_ADDRESS_SIZE(NAS)) bus ();

  connection_table_ctrl #(
    .DATA_WIDTH(DW),
    .NODE_ADDRESS_SIZE(NAS),
    .MIRROR_WRITES(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  // table model: write-then-read, read data one cycle later
  always @(posedge CLK) begin
    if (scramble) begin
      for (int i = 0; i < N; i++) tmem[i] <= DW'($urandom);
    end else if (bus.mem_cs) begin
      if (bus.mem_we) tmem[{bus.mem_node_A, bus.mem_node_B}] <= bus.mem_IN;
      else mout <= tmem[{bus.mem_node_A, bus.mem_node_B}];
    end
  end
  assign bus.mem_OUT = mout;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.rvalid0 === 1'b1 || bus.rvalid1 === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'(bus.rvalid1), 32'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        npop++;
        chk("rv_port", 32'(bus.rvalid1), e.port);
        chk("rv_both", 32'(bus.rvalid0 & bus.rvalid1), 0);
        chk("rdata", 32'(bus.rdata), e.data);
      end
    end
  end

  task automatic p0(input logic r, w, input int a, b, d);
    bus.req0 = r; bus.we0 = w;
    bus.node_A0 = NAS'(a); bus.node_B0 = NAS'(b); bus.wdata0 = DW'(d);
  endtask

  task automatic p1(input logic r, w, input int a, b, d);
    bus.req1 = r; bus.we1 = w;
    bus.node_A1 = NAS'(a); bus.node_B1 = NAS'(b); bus.wdata1 = DW'(d);
  endtask

  task automatic apply(input int p);
    logic w;
    int a, b, d;
    exp_t e;
    w = p ? bus.we1 : bus.we0;
    a = p ? int'(bus.node_A1) : int'(bus.node_A0);
    b = p ? int'(bus.node_B1) : int'(bus.node_B0);
    d = p ? int'(bus.wdata1) : int'(bus.wdata0);
    if (w) begin
      refm[a * 16 + b] = d;
      if (a != b) refm[b * 16 + a] = d;
    end else begin
      e.port = 32'(p);
      e.data = 32'(refm[a * 16 + b]);
      exp_q.push_back(e);
      npush++;
    end
  endtask

  task automatic step(input logic eg0, eg1, input string tag);
    @(negedge CLK);
    chk({tag, "_gnt0"}, 32'(bus.gnt0), 32'(eg0));
    chk({tag, "_gnt1"}, 32'(bus.gnt1), 32'(eg1));
    if (eg0) apply(0);
    if (eg1) apply(1);
    @(posedge CLK); #1;
  endtask

  task automatic mirror_chk(input int ma, mb, md, input string tag);
    @(negedge CLK);
    chk({tag, "_gnt0"}, 32'(bus.gnt0), 0);
    chk({tag, "_gnt1"}, 32'(bus.gnt1), 0);
    chk({tag, "_cs"}, 32'(bus.mem_cs & bus.mem_we), 1);
    chk({tag, "_addr"}, 32'({bus.mem_node_A, bus.mem_node_B}),
        32'(ma * 16 + mb));
    chk({tag, "_data"}, 32'(bus.mem_IN), 32'(md));
    @(posedge CLK); #1;
  endtask

  task automatic wait_clear(input int n0, input string tag);
    int n, bad, nz;
    n = n0; bad = 0; nz = 0;
    while (bus.init_done !== 1'b1 && n < 1000) begin
      if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) bad++;
      @(negedge CLK);
      n++;
    end
    chk({tag, "_cycles"}, 32'(n), 32'(n0 + N));
    chk({tag, "_gnt_in_clear"}, 32'(bad), 0);
    for (int i = 0; i < N; i++) if (tmem[i] !== '0) nz++;
    chk({tag, "_all_zero"}, 32'(nz), 0);
  endtask

  initial begin
    p0(0, 0, 0, 0, 0);
    p1(0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) refm[i] = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_init_done", 32'(bus.init_done), 0);
    chk("rst_gnt", 32'({bus.gnt0, bus.gnt1}), 0);
    chk("rst_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 0);
    chk("rst_cs", 32'(bus.mem_cs), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    scramble = 1'b0;

    @(negedge CLK);
    chk("clear_init_lo", 32'(bus.init_done), 0);
    chk("clear_cs", 32'({bus.mem_cs, bus.mem_we}), 3);
    wait_clear(0, "clr1");
    @(posedge CLK); #1;

    p0(1, 0, 3, 7, 0);       step(1, 0, "rd37");
    p0(0, 0, 0, 0, 0);       step(0, 0, "idle1");

    p0(1, 1, 10, 12, 42);    step(1, 0, "wr1012");
    p0(1, 0, 10, 12, 0);     mirror_chk(12, 10, 42, "mir1012");
    step(1, 0, "rd1012");
    p0(1, 0, 12, 10, 0);     step(1, 0, "rd1210");
    p0(0, 0, 0, 0, 0);       step(0, 0, "idle2");

    p1(1, 1, 1, 2, 9);       step(0, 1, "wr12");
    p1(0, 0, 0, 0, 0);       mirror_chk(2, 1, 9, "mir12");
    p0(1, 0, 2, 1, 0);
    p1(1, 0, 3, 4, 0);
    step(1, 0, "arb0");
    step(0, 1, "arb1");
    step(1, 0, "arb2");
    step(0, 1, "arb3");
    p0(0, 0, 0, 0, 0);
    p1(0, 0, 0, 0, 0);       step(0, 0, "idle3");

    p0(1, 1, 5, 5, 17);      step(1, 0, "wr55");
    p0(1, 0, 5, 5, 0);       step(1, 0, "rd55");
    p0(0, 0, 0, 0, 0);       step(0, 0, "idle4");

    p0(1, 1, 6, 9, 33);      step(1, 0, "wr69");
    RST = 1'b1;
    p0(0, 0, 0, 0, 0);
    p1(1, 0, 9, 6, 0);
    @(negedge CLK);
    chk("rstmir_gnt", 32'({bus.gnt0, bus.gnt1}), 0);
    chk("rstmir_cs", 32'(bus.mem_cs), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < N; i++) refm[i] = 0;
    @(negedge CLK);
    chk("rstmir_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 0);
    chk("rstmir_init", 32'(bus.init_done), 0);
    wait_clear(1, "clr2");
    chk("first_run_gnt1", 32'(bus.gnt1), 1);
    chk("first_run_gnt0", 32'(bus.gnt0), 0);
    if (bus.gnt1 === 1'b1) apply(1);
    @(posedge CLK); #1;
    p1(1, 0, 6, 9, 0);       step(0, 1, "rd69");
    p1(1, 0, 12, 10, 0);     step(0, 1, "rd1210b");
    p1(0, 0, 0, 0, 0);       step(0, 0, "idle5");
    step(0, 0, "idle6");

    chk("sb_empty", 32'(exp_q.size()), 0);
    chk("sb_reads", 32'(npop), 32'(npush));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
